// File: rtl/data_mem_arbiter.sv
// Sequencer/arbiter sharing the byte-addressed data memory between the CPU MEM stage and the debug dump walker.
// Build option: define DATA_MEM_ARB_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them down.
module data_mem_arbiter #(
    parameter int unsigned NUM_BITS  = 32,
    parameter int unsigned NUM_SLOTS = 128,
    parameter int unsigned NUM_DIREC = $clog2(NUM_SLOTS),
    parameter int unsigned CNT_W     = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cpu_req,
    input  logic                    i_cpu_we,
    input  logic [1:0]              i_cpu_size,
    input  logic                    i_cpu_unsigned,
    input  logic [NUM_DIREC-1:0]    i_cpu_addr,
    input  logic [NUM_BITS-1:0]     i_cpu_wdata,
    output logic [NUM_BITS-1:0]     o_cpu_rdata,
    output logic                    o_cpu_ready,
    output logic                    o_cpu_misalign,
    input  logic                    i_dbg_start,
    input  logic [NUM_DIREC-1:0]    i_dbg_base,
    input  logic [CNT_W-1:0]        i_dbg_count,
    input  logic                    i_dbg_ack,
    output logic [NUM_BITS-1:0]     o_dbg_word,
    output logic                    o_dbg_valid,
    output logic                    o_dbg_busy,
    output logic                    o_dbg_done,
    output logic                    o_mem_we,
    output logic [NUM_BITS/8-1:0]   o_mem_byte_enb,
    output logic [NUM_DIREC-1:0]    o_mem_addr,
    output logic [NUM_BITS-1:0]     o_mem_wdata,
    input  logic [NUM_BITS-1:0]     i_mem_rdata
);

    localparam int unsigned NB = NUM_BITS / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU_ISSUE,
        S_CPU_RESP,
        S_DUMP_ISSUE,
        S_DUMP_HOLD
    } state_e;

    state_e                 state_q, state_d;

    logic [NUM_BITS-1:0]    cpu_rdata_q, cpu_rdata_d;
    logic                   cpu_ready_q, cpu_ready_d;
    logic                   cpu_misalign_q, cpu_misalign_d;
    logic [NUM_BITS-1:0]    dbg_word_q, dbg_word_d;
    logic                   dbg_valid_q, dbg_valid_d;
    logic                   dbg_busy_q, dbg_busy_d;
    logic                   dbg_done_q, dbg_done_d;
    logic                   mem_we_q, mem_we_d;
    logic [NB-1:0]          mem_enb_q, mem_enb_d;
    logic [NUM_DIREC-1:0]   mem_addr_q, mem_addr_d;
    logic [NUM_BITS-1:0]    mem_wdata_q, mem_wdata_d;

    logic                   req_we_q, req_we_d;
    logic [1:0]             req_size_q, req_size_d;
    logic                   req_uns_q, req_uns_d;
    logic                   req_trap_q, req_trap_d;
    logic [NUM_DIREC-1:0]   dump_addr_q, dump_addr_d;
    logic [CNT_W-1:0]       dump_left_q, dump_left_d;

    logic                   cpu_is_half_c;
    logic                   cpu_is_word_c;
    logic                   cpu_trap_c;
    logic [NUM_DIREC-1:0]   cpu_addr_c;
    logic [NB-1:0]          cpu_enb_c;
    logic                   cpu_go;
    logic                   dump_go;

    assign cpu_is_half_c = (i_cpu_size == 2'b01);
    assign cpu_is_word_c = i_cpu_size[1];

    // Misalignment either traps the access or silently clears the low address bits.
`ifdef DATA_MEM_ARB_MISALIGN_TRAP_EN
    assign cpu_trap_c = (cpu_is_half_c && i_cpu_addr[0]) ||
                        (cpu_is_word_c && (i_cpu_addr[1:0] != 2'b00));
    assign cpu_addr_c = i_cpu_addr;
`else
    assign cpu_trap_c = 1'b0;
    always_comb begin
        cpu_addr_c = i_cpu_addr;
        if (cpu_is_word_c) begin
            cpu_addr_c[1:0] = 2'b00;
        end else if (cpu_is_half_c) begin
            cpu_addr_c[0] = 1'b0;
        end
    end
`endif

    always_comb begin
        if (cpu_is_word_c) begin
            cpu_enb_c = '1;
        end else if (cpu_is_half_c) begin
            cpu_enb_c = NB'(3);
        end else begin
            cpu_enb_c = NB'(1);
        end
    end

    // Lane 0 holds the byte at the access address, so loads extend straight from the low lanes.
    function automatic logic [NUM_BITS-1:0] extend_load(
        input logic [NUM_BITS-1:0] raw,
        input logic [1:0]          size,
        input logic                uns
    );
        logic [NUM_BITS-1:0] res;
        case (size)
            2'b00:   res = uns ? NUM_BITS'(raw[7:0])  : {{(NUM_BITS-8){raw[7]}},   raw[7:0]};
            2'b01:   res = uns ? NUM_BITS'(raw[15:0]) : {{(NUM_BITS-16){raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d        = state_q;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_ready_d    = 1'b0;
        cpu_misalign_d = 1'b0;
        dbg_word_d     = dbg_word_q;
        dbg_valid_d    = dbg_valid_q;
        dbg_busy_d     = dbg_busy_q;
        dbg_done_d     = 1'b0;
        mem_we_d       = 1'b0;
        mem_enb_d      = '0;
        mem_addr_d     = '0;
        mem_wdata_d    = '0;
        req_we_d       = req_we_q;
        req_size_d     = req_size_q;
        req_uns_d      = req_uns_q;
        req_trap_d     = req_trap_q;
        dump_addr_d    = dump_addr_q;
        dump_left_d    = dump_left_q;
        cpu_go         = 1'b0;
        dump_go        = 1'b0;

        // Dump bookkeeping runs in every state so an ack is honoured even while the CPU owns the memory.
        if (!dbg_busy_q && i_dbg_start) begin
            if (i_dbg_count == '0) begin
                dbg_done_d = 1'b1;
            end else begin
                dbg_busy_d  = 1'b1;
                dump_addr_d = i_dbg_base;
                dump_left_d = i_dbg_count;
            end
        end
        if (dbg_valid_q && i_dbg_ack) begin
            dbg_valid_d = 1'b0;
            dump_addr_d = dump_addr_q + NUM_DIREC'(NB);
            dump_left_d = dump_left_q - CNT_W'(1);
            if (dump_left_q == CNT_W'(1)) begin
                dbg_busy_d = 1'b0;
                dbg_done_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_cpu_req) begin
                    cpu_go = 1'b1;
                end else if (dbg_busy_q && !dbg_valid_q) begin
                    dump_go = 1'b1;
                end
            end
            S_CPU_ISSUE: begin
                state_d        = S_CPU_RESP;
                cpu_ready_d    = 1'b1;
                cpu_misalign_d = req_trap_q;
                cpu_rdata_d    = (req_we_q || req_trap_q) ? '0
                                 : extend_load(i_mem_rdata, req_size_q, req_uns_q);
            end
            S_CPU_RESP: begin
                state_d = S_IDLE;
            end
            S_DUMP_ISSUE: begin
                state_d     = S_DUMP_HOLD;
                dbg_word_d  = i_mem_rdata;
                dbg_valid_d = 1'b1;
            end
            S_DUMP_HOLD: begin
                if (i_cpu_req) begin
                    cpu_go = 1'b1;
                end else if (i_dbg_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cpu_go) begin
            state_d     = S_CPU_ISSUE;
            req_we_d    = i_cpu_we;
            req_size_d  = i_cpu_size;
            req_uns_d   = i_cpu_unsigned;
            req_trap_d  = cpu_trap_c;
            mem_we_d    = i_cpu_we && !cpu_trap_c;
            mem_enb_d   = cpu_trap_c ? '0 : cpu_enb_c;
            mem_addr_d  = cpu_addr_c;
            mem_wdata_d = i_cpu_wdata;
        end else if (dump_go) begin
            state_d    = S_DUMP_ISSUE;
            mem_enb_d  = '1;
            mem_addr_d = dump_addr_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q        <= S_IDLE;
            cpu_rdata_q    <= '0;
            cpu_ready_q    <= 1'b0;
            cpu_misalign_q <= 1'b0;
            dbg_word_q     <= '0;
            dbg_valid_q    <= 1'b0;
            dbg_busy_q     <= 1'b0;
            dbg_done_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_enb_q      <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            req_we_q       <= 1'b0;
            req_size_q     <= 2'b00;
            req_uns_q      <= 1'b0;
            req_trap_q     <= 1'b0;
            dump_addr_q    <= '0;
            dump_left_q    <= '0;
        end else begin
            state_q        <= state_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_ready_q    <= cpu_ready_d;
            cpu_misalign_q <= cpu_misalign_d;
            dbg_word_q     <= dbg_word_d;
            dbg_valid_q    <= dbg_valid_d;
            dbg_busy_q     <= dbg_busy_d;
            dbg_done_q     <= dbg_done_d;
            mem_we_q       <= mem_we_d;
            mem_enb_q      <= mem_enb_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            req_we_q       <= req_we_d;
            req_size_q     <= req_size_d;
            req_uns_q      <= req_uns_d;
            req_trap_q     <= req_trap_d;
            dump_addr_q    <= dump_addr_d;
            dump_left_q    <= dump_left_d;
        end
    end

    assign o_cpu_rdata    = cpu_rdata_q;
    assign o_cpu_ready    = cpu_ready_q;
    assign o_cpu_misalign = cpu_misalign_q;
    assign o_dbg_word     = dbg_word_q;
    assign o_dbg_valid    = dbg_valid_q;
    assign o_dbg_busy     = dbg_busy_q;
    assign o_dbg_done     = dbg_done_q;
    assign o_mem_we       = mem_we_q;
    assign o_mem_byte_enb = mem_enb_q;
    assign o_mem_addr     = mem_addr_q;
    assign o_mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: byte-array reference model, randomized CPU traffic and dumps.
// Follows DATA_MEM_ARB_MISALIGN_TRAP_EN the same way as the design build.
module tb_data_mem_arbiter;

    localparam int NUM_BITS  = 32;
    localparam int NUM_SLOTS = 128;
    localparam int NUM_DIREC = 7;
    localparam int CNT_W     = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cpu_req = 1'b0, cpu_we = 1'b0, cpu_uns = 1'b0;
    logic [1:0]            cpu_size = 2'b00;
    logic [NUM_DIREC-1:0]  cpu_addr = '0;
    logic [NUM_BITS-1:0]   cpu_wdata = '0;
    logic [NUM_BITS-1:0]   cpu_rdata;
    logic                  cpu_ready, cpu_misalign;
    logic                  dbg_start = 1'b0, dbg_ack = 1'b0;
    logic [NUM_DIREC-1:0]  dbg_base = '0;
    logic [CNT_W-1:0]      dbg_count = '0;
    logic [NUM_BITS-1:0]   dbg_word;
    logic                  dbg_valid, dbg_busy, dbg_done;
    logic                  mem_we;
    logic [3:0]            mem_enb;
    logic [NUM_DIREC-1:0]  mem_addr;
    logic [NUM_BITS-1:0]   mem_wdata;
    logic [NUM_BITS-1:0]   mem_rdata = '0;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .NUM_BITS(NUM_BITS), .NUM_SLOTS(NUM_SLOTS), .NUM_DIREC(NUM_DIREC), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_size(cpu_size), .i_cpu_unsigned(cpu_uns),
        .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata),
        .o_cpu_ready(cpu_ready), .o_cpu_misalign(cpu_misalign),
        .i_dbg_start(dbg_start), .i_dbg_base(dbg_base), .i_dbg_count(dbg_count), .i_dbg_ack(dbg_ack),
        .o_dbg_word(dbg_word), .o_dbg_valid(dbg_valid), .o_dbg_busy(dbg_busy), .o_dbg_done(dbg_done),
        .o_mem_we(mem_we), .o_mem_byte_enb(mem_enb), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Environment memory: lane-masked read on negedge, byte-enabled write on posedge.
    logic [7:0] env_mem  [NUM_SLOTS];
    logic [7:0] init_img [NUM_SLOTS];
    logic [7:0] ref_mem  [NUM_SLOTS];
    bit         mem_init_req = 1'b0;

    always @(negedge clk) begin
        logic [31:0] rd;
        rd = '0;
        for (int k = 0; k < 4; k++)
            if (mem_enb[k] === 1'b1) rd[8*k +: 8] = env_mem[(int'(mem_addr) + k) % NUM_SLOTS];
        mem_rdata = rd;
    end

    always @(posedge clk) begin
        if (mem_init_req) begin
            for (int i = 0; i < NUM_SLOTS; i++) env_mem[i] <= init_img[i];
        end else if (mem_we === 1'b1) begin
            for (int k = 0; k < 4; k++)
                if (mem_enb[k]) env_mem[(int'(mem_addr) + k) % NUM_SLOTS] <= mem_wdata[8*k +: 8];
        end
    end

    typedef struct packed { logic [31:0] rdata; logic misalign; } cpu_exp_t;
    cpu_exp_t    cpu_q[$];
    logic [31:0] dump_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // Reference: accesses as byte ranges of ref_mem, loads as integers with two's-complement extension.
    function automatic cpu_exp_t ref_cpu(input logic we, input logic [1:0] size, input logic uns,
                                         input int addr, input logic [31:0] wdata);
        cpu_exp_t e;
        int       nb;
        int       a;
        longint   v;
        e.rdata    = '0;
        e.misalign = 1'b0;
        nb = size_bytes(size);
        a  = addr;
        if (a % nb != 0) begin
`ifdef DATA_MEM_ARB_MISALIGN_TRAP_EN
            e.misalign = 1'b1;
            return e;
`else
            a = a - (a % nb);
`endif
        end
        if (we) begin
            for (int k = 0; k < nb; k++) ref_mem[(a + k) % NUM_SLOTS] = wdata[8*k +: 8];
        end else begin
            v = 0;
            for (int k = 0; k < nb; k++) v = v + (longint'(ref_mem[(a + k) % NUM_SLOTS]) << (8*k));
            if (!uns && nb < 4 && v >= (longint'(1) << (8*nb - 1))) v = v - (longint'(1) << (8*nb));
            e.rdata = 32'(v);
        end
        return e;
    endfunction

    // CPU driver; with exact set the memory is idle so the issue cycle and 2-cycle latency are checked.
    task automatic cpu_op(input logic we, input logic [1:0] size, input logic uns,
                          input int addr, input logic [31:0] wdata, input bit exact);
        int       lat;
        int       nb;
        bit       mis;
        int       exp_addr;
        logic [3:0] exp_enb;
        logic     exp_we;
        nb  = size_bytes(size);
        mis = (addr % nb) != 0;
        exp_enb = (nb == 1) ? 4'h1 : (nb == 2) ? 4'h3 : 4'hF;
`ifdef DATA_MEM_ARB_MISALIGN_TRAP_EN
        exp_addr = addr;
        if (mis) exp_enb = 4'h0;
        exp_we = we && !mis;
`else
        exp_addr = addr - (addr % nb);
        exp_we = we;
`endif
        cpu_q.push_back(ref_cpu(we, size, uns, addr, wdata));
        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_uns = uns;
        cpu_addr = NUM_DIREC'(addr); cpu_wdata = wdata;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (exact && lat == 1) begin
                check("issue_addr", 32'(mem_addr), 32'(exp_addr));
                check("issue_enb", 32'(mem_enb), 32'(exp_enb));
                check("issue_we", 32'(mem_we), 32'(exp_we));
            end
        end while (!cpu_ready && lat < 20);
        cpu_req = 1'b0;
        if (exact) check("cpu_latency", 32'(lat), 32'd2);
        else       check("cpu_latency_le3", 32'(lat <= 3), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic dump_run(input int base, input int count, input int ack_dly);
        int          d0;
        int          w;
        logic [31:0] word;
        d0 = done_cnt;
        for (int i = 0; i < count; i++) begin
            word = '0;
            for (int k = 0; k < 4; k++) word[8*k +: 8] = ref_mem[(base + 4*i + k) % NUM_SLOTS];
            dump_q.push_back(word);
        end
        dbg_start = 1'b1; dbg_base = NUM_DIREC'(base); dbg_count = CNT_W'(count);
        @(posedge clk); #1;
        dbg_start = 1'b0;
        if (count == 0) check("dump_zero_busy", 32'(dbg_busy), 32'd0);
        for (int i = 0; i < count; i++) begin
            w = 0;
            while (!dbg_valid && w < 60) begin @(posedge clk); #1; w++; end
            check("dump_valid_wait", 32'(w < 60), 32'd1);
            repeat (ack_dly) begin @(posedge clk); #1; end
            dbg_ack = 1'b1;
            @(posedge clk); #1;
            dbg_ack = 1'b0;
        end
        repeat (2) begin @(posedge clk); #1; end
        check("dump_done_once", 32'(done_cnt - d0), 32'd1);
        check("dump_busy_end", 32'(dbg_busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, cpu_rdata, 32'd0);
        check({tag, "_ready"}, 32'(cpu_ready), 32'd0);
        check({tag, "_misalign"}, 32'(cpu_misalign), 32'd0);
        check({tag, "_dbg_word"}, dbg_word, 32'd0);
        check({tag, "_dbg_valid"}, 32'(dbg_valid), 32'd0);
        check({tag, "_dbg_busy"}, 32'(dbg_busy), 32'd0);
        check({tag, "_dbg_done"}, 32'(dbg_done), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_enb"}, 32'(mem_enb), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // CPU response monitor.
    initial begin : cpu_mon
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ready === 1'b1) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = cpu_q.pop_front();
                    check("cpu_rdata", cpu_rdata, e.rdata);
                    check("cpu_misalign", 32'(cpu_misalign), 32'(e.misalign));
                end
            end
        end
    end

    // Dump monitor: compare on valid rise, then require the word to stay put while valid is held.
    initial begin : dump_mon
        logic        prev_valid;
        logic [31:0] held;
        prev_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (dbg_valid === 1'b1 && !prev_valid) begin
                if (dump_q.size() == 0) begin
                    check("dump_unexpected_word", 32'd1, 32'd0);
                end else begin
                    held = dump_q.pop_front();
                    check("dump_word", dbg_word, held);
                end
            end else if (dbg_valid === 1'b1) begin
                check("dump_word_hold", dbg_word, held);
            end
            prev_valid = (dbg_valid === 1'b1);
            if (dbg_done === 1'b1) done_cnt++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int we_seen;
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset asserted while a store sits in the issue cycle.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 7'h40; cpu_wdata = 32'h55AA_33CC;
        @(posedge clk); #1;
        check("rst_mid_sw_issue_we", 32'(mem_we), 32'd1);
        rst = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1;
        check_all_zero("rst_mid_sw");
        @(posedge clk); #1;
        rst = 1'b0;
        we_seen = 0;
        repeat (8) begin @(posedge clk); #1; if (mem_we !== 1'b0) we_seen++; end
        check("rst_mid_sw_no_we", 32'(we_seen), 32'd0);

        for (int i = 0; i < NUM_SLOTS; i++) begin
            init_img[i] = 8'($urandom);
            ref_mem[i]  = init_img[i];
        end
        mem_init_req = 1'b1;
        @(posedge clk); #1;
        mem_init_req = 1'b0;

        cpu_op(1'b1, 2'b10, 1'b0, 'h10, 32'hDEADBEEF, 1'b1);
        cpu_op(1'b0, 2'b00, 1'b0, 'h13, 32'h0, 1'b1);
        cpu_op(1'b0, 2'b00, 1'b1, 'h13, 32'h0, 1'b1);
        cpu_op(1'b1, 2'b01, 1'b0, 'h20, 32'h0000_1234, 1'b1);
        cpu_op(1'b0, 2'b01, 1'b0, 'h20, 32'h0, 1'b1);
        cpu_op(1'b0, 2'b10, 1'b0, 'h22, 32'h0, 1'b1);
        cpu_op(1'b1, 2'b10, 1'b0, 'h22, 32'hCAFEF00D, 1'b1);
        cpu_op(1'b0, 2'b10, 1'b0, 'h20, 32'h0, 1'b1);
        cpu_op(1'b0, 2'b11, 1'b0, 'h14, 32'h0, 1'b1);

        dump_run('h10, 2, 3);
        dump_run('h30, 0, 0);
        dump_run('h7C, 3, 1);

        // CPU load landing while the first dump word is held.
        fork
            dump_run('h10, 2, 6);
            begin
                n = 0;
                while (!dbg_valid && n < 60) begin @(posedge clk); #1; n++; end
                cpu_op(1'b0, 2'b10, 1'b0, 'h40, 32'h0, 1'b1);
            end
        join

        for (int i = 0; i < 200; i++)
            cpu_op(1'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, NUM_SLOTS-1)),
                   $urandom, 1'b1);

        // Dumps with concurrent CPU loads (no stores, so the dump image is stable).
        for (int r = 0; r < 25; r++) begin
            fork
                dump_run(int'($urandom_range(0, NUM_SLOTS-1)), int'($urandom_range(1, 4)),
                         int'($urandom_range(0, 5)));
                begin
                    n = int'($urandom_range(0, 5));
                    for (int j = 0; j < n; j++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        cpu_op(1'b0, 2'($urandom), 1'($urandom),
                               int'($urandom_range(0, NUM_SLOTS-1)), 32'h0, 1'b0);
                    end
                end
            join
        end

        repeat (4) begin @(posedge clk); #1; end
        check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        check("dump_queue_drained", 32'(dump_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
